adder_sum_accumulator: RTL and testbench
========================================

Name: adder_sum_accumulator

Overview:
- Downstream consumer of the 3-bit result of the 2-bit adder stage (the sum bus s).
- Accepts a programmable number of sums over a valid/ready handshake and accumulates them into a wider register.
- Presents the total on an output valid/ready handshake.
- Turns the combinational adder into a multi-cycle summing datapath for the next stage.

Parameters:
- SUM_W, 3, width of incoming sum (matches adder output s[2:0]).
- ACC_W, 8, accumulator/result width; must be >= SUM_W.
- NUM_SAMPLES, 4, sums accepted per accumulation run; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- s_in  input  SUM_W  sum from adder stage.
- s_valid  input  1  s_in valid this cycle.
- s_ready  output  1  block accepts s_in this cycle.
- acc_out  output  ACC_W  accumulator value.
- acc_valid  output  1  acc_out is final run result.
- acc_ready  input  1  downstream accepts result.
- busy  output  1  high in ACCUM or DONE.
- overflow  output  1  sticky: carry out of ACC_W occurred during the current run.

Behaviour:
- Reset: one clock, clk; asynchronous active-high reset, rst. While rst is high:
  - state=IDLE, acc=0, cnt=0, overflow=0.
  - acc_valid=0, s_ready=0, busy=0, acc_out=0.
- Outputs decode from registered state/registers only; no combinational input-to-output paths.
  - s_ready = (state==ACCUM).
  - acc_valid = (state==DONE).
  - busy = (state!=IDLE).
  - acc_out = acc at all times.
- Transfer rules:
  - Input transfer occurs on a rising edge with s_valid & s_ready.
  - Output transfer occurs on a rising edge with acc_valid & acc_ready.
- IDLE:
  - start=1 -> acc<=0, cnt<=0, overflow<=0, state<=ACCUM.
  - Otherwise hold all registers.
- ACCUM, on input transfer:
  - acc <= (acc + zero-extended s_in) mod 2^ACC_W.
  - If the true sum >= 2^ACC_W, overflow<=1 (sticky).
  - cnt <= cnt+1.
  - If cnt==NUM_SAMPLES-1 at the transfer, state<=DONE and cnt<=0.
  - With no transfer (s_valid low), hold everything; gaps of any length are allowed.
- DONE:
  - acc_out and overflow hold stable.
  - On output transfer, state<=IDLE; acc and overflow keep their values until the next start.
- Latency:
  - The final input transfer at edge N raises acc_valid from edge N (result visible in the cycle after the last accepted sum).
  - Minimum run is NUM_SAMPLES+2 cycles including start and the result handshake.
- start is ignored in ACCUM and DONE; there is no restart mid-run.
- The cycle carrying start sees s_ready=0, so no sum is taken in that cycle.
- s_in is ignored whenever s_ready=0.
- Reset mid-run aborts immediately to the reset values; a partially accumulated sum is discarded.
- cnt width: clog2(NUM_SAMPLES), minimum 1 bit.
  - NUM_SAMPLES=1: a single transfer goes straight to DONE.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on carry out, acc <= all ones (2^ACC_W-1) and stays saturated for the rest of the run; overflow is still set.
- Undefined: wrap-around modulo 2^ACC_W as above.

Test Plan:
- Basic run, defaults (ACC_W=8, NUM_SAMPLES=4):
  - Stimulus: start, then sums 7,7,7,7 with s_valid held high.
  - Required: acc_valid high the cycle after the 4th transfer, acc_out=28, overflow=0; acc_ready=1 returns to IDLE, busy=0.
- Backpressure and gaps:
  - Stimulus: sums 1,2,3,4 with s_valid low 3 cycles between each; acc_ready held low 5 cycles after DONE.
  - Required: acc_out=10 stable and acc_valid high for all 5 cycles; start pulsed during DONE is ignored.
- Overflow, wrap (ACC_W=4, ACC_SATURATE_EN undefined):
  - Stimulus: sums 7,7,7,7.
  - Required: acc_out=12, overflow=1.
- Overflow, saturate (ACC_W=4, ACC_SATURATE_EN defined):
  - Stimulus: sums 7,7,7,7.
  - Required: acc_out=15 from the 3rd transfer on, overflow=1.
- Reset mid-run:
  - Stimulus: after 2 accepted sums (5,6), assert rst asynchronously between edges.
  - Required: acc_out=0, busy=0, s_ready=0, acc_valid=0 immediately.
  - Required: a new start then accepts 4 sums of 1 -> acc_out=4.
- NUM_SAMPLES=1:
  - Stimulus: start, single sum 6.
  - Required: acc_valid next cycle, acc_out=6; s_ready low in the start cycle and in DONE.

Source files
------------

// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between the adder stage, the sum accumulator and the downstream consumer.
// master drives start/sums/result-ready; slave (the accumulator) drives ready, result and status.
interface adder_sum_accumulator_if #(
    parameter int SUM_W = 3,
    parameter int ACC_W = 8
);
    logic             start;
    logic [SUM_W-1:0] s_in;
    logic             s_valid;
    logic             s_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             busy;
    logic             overflow;

    modport master (
        output start, s_in, s_valid, acc_ready,
        input  s_ready, acc_out, acc_valid, busy, overflow
    );

    modport slave (
        input  start, s_in, s_valid, acc_ready,
        output s_ready, acc_out, acc_valid, busy, overflow
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Sums NUM_SAMPLES adder results (valid/ready in, valid/ready out); result valid the cycle after the last sum,
// held until accepted. ACC_SATURATE_EN clamps the accumulator to all ones on carry out instead of wrapping.
module adder_sum_accumulator #(
    parameter int SUM_W       = 3,
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    adder_sum_accumulator_if.slave   bus
);
    localparam int CNT_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.s_in};
    assign carry    = sum_wide[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, every further add carries again (or adds zero), so the value stays all ones.
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign acc_next = sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.s_valid) begin
                    acc_d = acc_next;
                    if (carry) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // acc and overflow are left untouched so the last result stays readable in IDLE.
                if (bus.acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_ready   = (state_q == ACCUM);
    assign bus.acc_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench: three accumulators (8-bit/4 samples, 4-bit/4 samples, 8-bit/1 sample) driven from a vector table.
module tb_adder_sum_accumulator;
    logic clk;
    logic rst;

    adder_sum_accumulator_if #(.SUM_W(3), .ACC_W(8)) if0 ();
    adder_sum_accumulator_if #(.SUM_W(3), .ACC_W(4)) if1 ();
    adder_sum_accumulator_if #(.SUM_W(3), .ACC_W(8)) if2 ();

    adder_sum_accumulator #(.SUM_W(3), .ACC_W(8), .NUM_SAMPLES(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    adder_sum_accumulator #(.SUM_W(3), .ACC_W(4), .NUM_SAMPLES(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    adder_sum_accumulator #(.SUM_W(3), .ACC_W(8), .NUM_SAMPLES(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [2:0]      start_v, sval_v, ardy_v;
    logic [2:0][2:0] sin_v;
    logic [2:0]      srdy_o, aval_o, busy_o, ovf_o;
    logic [2:0][7:0] acc_o;

    assign if0.start = start_v[0];  assign if1.start = start_v[1];  assign if2.start = start_v[2];
    assign if0.s_valid = sval_v[0]; assign if1.s_valid = sval_v[1]; assign if2.s_valid = sval_v[2];
    assign if0.acc_ready = ardy_v[0]; assign if1.acc_ready = ardy_v[1]; assign if2.acc_ready = ardy_v[2];
    assign if0.s_in = sin_v[0];     assign if1.s_in = sin_v[1];     assign if2.s_in = sin_v[2];

    assign srdy_o = {if2.s_ready, if1.s_ready, if0.s_ready};
    assign aval_o = {if2.acc_valid, if1.acc_valid, if0.acc_valid};
    assign busy_o = {if2.busy, if1.busy, if0.busy};
    assign ovf_o  = {if2.overflow, if1.overflow, if0.overflow};
    assign acc_o  = {if2.acc_out, 4'b0000, if1.acc_out, if0.acc_out};

    typedef struct {
        int              k;
        int              n;
        logic [3:0][2:0] s;
        int              gap;
        int              hold;
        int              exp_acc;
        int              exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input int k, input int n, input int s0, input int s1, input int s2, input int s3,
                           input int gap, input int hold, input int exp_acc, input int exp_ovf);
        vec_t v;
        v.k = k; v.n = n; v.gap = gap; v.hold = hold; v.exp_acc = exp_acc; v.exp_ovf = exp_ovf;
        v.s[0] = 3'(s0); v.s[1] = 3'(s1); v.s[2] = 3'(s2); v.s[3] = 3'(s3);
        vecs.push_back(v);
    endtask

    // Starts a run at a negedge in IDLE, feeds the sums, checks each step against a small model, then drains.
    task automatic run(input vec_t v);
        int  k;
        int  w;
        int  m;
        int  ov;
        k = v.k;
        w = (k == 1) ? 4 : 8;
        m = 0;
        ov = 0;
        chk("idle_s_ready", k, int'(srdy_o[k]), 0);
        start_v[k] = 1'b1;
        sval_v[k]  = 1'b1;
        sin_v[k]   = 3'd7;
        step();
        start_v[k] = 1'b0;
        sval_v[k]  = 1'b0;
        chk("start_busy", k, int'(busy_o[k]), 1);
        chk("start_acc_clear", k, int'(acc_o[k]), 0);
        chk("start_ovf_clear", k, int'(ovf_o[k]), 0);
        chk("accum_s_ready", k, int'(srdy_o[k]), 1);
        for (int i = 0; i < v.n; i++) begin
            sval_v[k] = 1'b1;
            sin_v[k]  = v.s[i];
            step();
            sval_v[k] = 1'b0;
            sin_v[k]  = 3'd7;
            m += int'(v.s[i]);
            if (m >= (1 << w)) begin
                ov = 1;
`ifdef ACC_SATURATE_EN
                m = (1 << w) - 1;
`else
                m = m - (1 << w);
`endif
            end
            chk("xfer_acc", k, int'(acc_o[k]), m);
            chk("xfer_ovf", k, int'(ovf_o[k]), ov);
            if (i < v.n - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    step();
                    chk("gap_hold_acc", k, int'(acc_o[k]), m);
                    chk("gap_valid_low", k, int'(aval_o[k]), 0);
                end
            end
        end
        chk("done_valid", k, int'(aval_o[k]), 1);
        chk("done_s_ready", k, int'(srdy_o[k]), 0);
        chk("final_acc", k, int'(acc_o[k]), v.exp_acc);
        chk("final_ovf", k, int'(ovf_o[k]), v.exp_ovf);
        for (int h = 0; h < v.hold; h++) begin
            start_v[k] = (h == 1);
            step();
            start_v[k] = 1'b0;
            chk("bp_valid", k, int'(aval_o[k]), 1);
            chk("bp_acc_stable", k, int'(acc_o[k]), v.exp_acc);
            chk("bp_ovf_stable", k, int'(ovf_o[k]), v.exp_ovf);
        end
        ardy_v[k] = 1'b1;
        step();
        ardy_v[k] = 1'b0;
        chk("ret_idle_busy", k, int'(busy_o[k]), 0);
        chk("ret_idle_valid", k, int'(aval_o[k]), 0);
        chk("idle_keep_acc", k, int'(acc_o[k]), v.exp_acc);
        chk("idle_keep_ovf", k, int'(ovf_o[k]), v.exp_ovf);
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        sval_v  = '0;
        ardy_v  = '0;
        sin_v   = '0;

        add_vec(0, 4, 7, 7, 7, 7, 0, 0, 28, 0);
        add_vec(0, 4, 1, 2, 3, 4, 3, 5, 10, 0);
`ifdef ACC_SATURATE_EN
        add_vec(1, 4, 7, 7, 7, 7, 0, 0, 15, 1);
`else
        add_vec(1, 4, 7, 7, 7, 7, 0, 0, 12, 1);
`endif
        add_vec(1, 4, 1, 2, 3, 4, 0, 0, 10, 0);
        add_vec(2, 1, 6, 0, 0, 0, 0, 2, 6, 0);
        add_vec(0, 4, 3, 0, 5, 2, 1, 0, 10, 0);

        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_acc", k, int'(acc_o[k]), 0);
            chk("rst_busy", k, int'(busy_o[k]), 0);
            chk("rst_s_ready", k, int'(srdy_o[k]), 0);
            chk("rst_valid", k, int'(aval_o[k]), 0);
            chk("rst_ovf", k, int'(ovf_o[k]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i]);
        end

        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        sval_v[0]  = 1'b1;
        sin_v[0]   = 3'd5;
        step();
        sin_v[0]   = 3'd6;
        step();
        sval_v[0]  = 1'b0;
        chk("midrun_acc", 0, int'(acc_o[0]), 11);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_acc", 0, int'(acc_o[0]), 0);
        chk("midrst_busy", 0, int'(busy_o[0]), 0);
        chk("midrst_s_ready", 0, int'(srdy_o[0]), 0);
        chk("midrst_valid", 0, int'(aval_o[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t v;
            v.k = 0; v.n = 4; v.gap = 0; v.hold = 0; v.exp_acc = 4; v.exp_ovf = 0;
            v.s[0] = 3'd1; v.s[1] = 3'd1; v.s[2] = 3'd1; v.s[3] = 3'd1;
            run(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
